// File: rtl/nios2_mul_result_combine_pkg.sv
// Shared CPU constants and stage payload layouts for the multiplier
// result-combine pipeline.
package nios2_mul_result_combine_pkg;

    localparam int MUL_W    = 32;
    localparam int HALF_W   = 16;
    localparam int REGNUM_W = 5;

    typedef struct packed {
        logic [MUL_W-1:0]    p1;
        logic [HALF_W-1:0]   mid;
        logic [REGNUM_W-1:0] tag;
    } mid_payload_t;

    typedef struct packed {
        logic [MUL_W-1:0]    result;
        logic [REGNUM_W-1:0] tag;
    } res_payload_t;

    function automatic bit latency_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/nios2_mul_stage_reg.sv
// Valid-plus-payload pipeline stage register with advance enable and flush.
module nios2_mul_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         flush,
    input  logic         vld_in,
    input  logic [W-1:0] data_in,
    output logic         vld_out,
    output logic [W-1:0] data_out
);

    logic         vld_d, vld_q;
    logic [W-1:0] data_d, data_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (en) begin
            vld_d = vld_in;
        end
        // Payload only moves with a real operation so outputs hold while idle.
        if (en && vld_in) begin
            data_d = data_in;
        end
        if (flush) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_out  = vld_q;
    assign data_out = data_q;

endmodule

// File: rtl/nios2_mul_result_combine.sv
// Combines three 16x16 partial products into the low 32 bits of a 32x32
// product, over one or two pipeline stages.
module nios2_mul_result_combine
    import nios2_mul_result_combine_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MUL_W-1:0]    M_mul_cell_p1,
    input  logic [MUL_W-1:0]    M_mul_cell_p2,
    input  logic [MUL_W-1:0]    M_mul_cell_p3,
    input  logic                M_mul_valid,
    input  logic [REGNUM_W-1:0] M_dst_regnum,
    input  logic                A_en,
    input  logic                A_flush,
    output logic [MUL_W-1:0]    A_mul_result,
    output logic                A_mul_valid,
    output logic [REGNUM_W-1:0] A_dst_regnum,
    output logic                A_mul_busy
);

    // The cross terms only affect bits 31:16, so their upper halves and the
    // carry out of the mid sum fall off the top of the 32-bit result.
    function automatic logic [HALF_W-1:0] mid_sum(input logic [MUL_W-1:0] p2,
                                                  input logic [MUL_W-1:0] p3);
        return p2[HALF_W-1:0] + p3[HALF_W-1:0];
    endfunction

    function automatic logic [MUL_W-1:0] final_sum(input logic [MUL_W-1:0]  p1,
                                                   input logic [HALF_W-1:0] mid);
        return p1 + {mid, {HALF_W{1'b0}}};
    endfunction

    logic unused_hi;
    assign unused_hi = ^{M_mul_cell_p2[MUL_W-1:HALF_W], M_mul_cell_p3[MUL_W-1:HALF_W]};

    if (!latency_legal(LATENCY)) begin : g_bad_latency
        $error("nios2_mul_result_combine: LATENCY must be 1 or 2");
    end

    res_payload_t res_in, res_out;
    logic         res_vld_in, res_vld_out;

    if (LATENCY == 2) begin : g_lat2
        mid_payload_t mid_in, mid_out;
        logic         mid_vld;

        always_comb begin
            mid_in.p1  = M_mul_cell_p1;
            mid_in.mid = mid_sum(M_mul_cell_p2, M_mul_cell_p3);
            mid_in.tag = M_dst_regnum;
        end

        // Stage 1: low partial, folded cross terms and tag
        nios2_mul_stage_reg #(.W($bits(mid_payload_t))) u_stage1 (
            .clk      (clk),
            .reset    (reset),
            .en       (A_en),
            .flush    (A_flush),
            .vld_in   (M_mul_valid),
            .data_in  (mid_in),
            .vld_out  (mid_vld),
            .data_out (mid_out)
        );

        always_comb begin
            res_in.result = final_sum(mid_out.p1, mid_out.mid);
            res_in.tag    = mid_out.tag;
            res_vld_in    = mid_vld;
        end

        assign A_mul_busy = mid_vld | res_vld_out;
    end else begin : g_lat1
        always_comb begin
            res_in.result = final_sum(M_mul_cell_p1, mid_sum(M_mul_cell_p2, M_mul_cell_p3));
            res_in.tag    = M_dst_regnum;
            res_vld_in    = M_mul_valid;
        end

        assign A_mul_busy = res_vld_out;
    end

    // Final stage: full low-word product and tag
    nios2_mul_stage_reg #(.W($bits(res_payload_t))) u_stage_res (
        .clk      (clk),
        .reset    (reset),
        .en       (A_en),
        .flush    (A_flush),
        .vld_in   (res_vld_in),
        .data_in  (res_in),
        .vld_out  (res_vld_out),
        .data_out (res_out)
    );

    assign A_mul_result = res_out.result;
    assign A_dst_regnum = res_out.tag;
    assign A_mul_valid  = res_vld_out;

endmodule

// File: tb/tb_nios2_mul_result_combine.sv
// Directed and streaming checks of the result-combine block at both latencies.
module tb_nios2_mul_result_combine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] p1 = '0, p2 = '0, p3 = '0;
    logic        m_vld = 1'b0;
    logic [4:0]  m_tag = '0;
    logic        en = 1'b1;
    logic        flush = 1'b0;

    logic [31:0] r1, r2;
    logic        v1, v2, b1, b2;
    logic [4:0]  t1, t2;

    int checks = 0;
    int failures = 0;
    logic [36:0] q1[$];
    logic [36:0] q2[$];
    int n1 = 0, n2 = 0;

    always #5 clk = ~clk;

    nios2_mul_result_combine #(.LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
        .M_mul_valid(m_vld), .M_dst_regnum(m_tag),
        .A_en(en), .A_flush(flush),
        .A_mul_result(r1), .A_mul_valid(v1), .A_dst_regnum(t1), .A_mul_busy(b1)
    );

    nios2_mul_result_combine #(.LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset),
        .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3),
        .M_mul_valid(m_vld), .M_dst_regnum(m_tag),
        .A_en(en), .A_flush(flush),
        .A_mul_result(r2), .A_mul_valid(v2), .A_dst_regnum(t2), .A_mul_busy(b2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] tag);
        logic [31:0] a_lo, a_hi, b_lo, b_hi;
        a_lo = {16'h0, s1[15:0]};
        a_hi = {16'h0, s1[31:16]};
        b_lo = {16'h0, s2[15:0]};
        b_hi = {16'h0, s2[31:16]};
        p1 = a_lo * b_lo;
        p2 = a_lo * b_hi;
        p3 = a_hi * b_lo;
        m_tag = tag;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_v1"}, {31'h0, v1}, 32'h0);
        check({tag, "_v2"}, {31'h0, v2}, 32'h0);
        check({tag, "_b1"}, {31'h0, b1}, 32'h0);
        check({tag, "_b2"}, {31'h0, b2}, 32'h0);
    endtask

    task automatic mon;
        logic [36:0] e;
        if (v1) begin
            if (q1.size() == 0) check("l1_spurious", 32'h1, 32'h0);
            else begin
                e = q1.pop_front();
                n1++;
                check("l1_res", r1, e[31:0]);
                check("l1_tag", {27'h0, t1}, {27'h0, e[36:32]});
            end
        end
        if (v2) begin
            if (q2.size() == 0) check("l2_spurious", 32'h1, 32'h0);
            else begin
                e = q2.pop_front();
                n2++;
                check("l2_res", r2, e[31:0]);
                check("l2_tag", {27'h0, t2}, {27'h0, e[36:32]});
            end
        end
    endtask

    initial begin
        logic [31:0] s1, s2, prod;
        logic [4:0]  tg;

        // Reset state
        tick;
        check_idle("rst");
        check("rst_r1", r1, 32'h0);
        check("rst_r2", r2, 32'h0);
        check("rst_t1", {27'h0, t1}, 32'h0);
        check("rst_t2", {27'h0, t2}, 32'h0);
        reset = 1'b0;

        // Basic product, captured on the first edge after reset release
        set_op(32'h0001_0002, 32'h0003_0004, 5'd7);
        check("basic_p1", p1, 32'd8);
        m_vld = 1'b1;
        tick;
        m_vld = 1'b0;
        check("basic_v1", {31'h0, v1}, 32'h1);
        check("basic_r1", r1, 32'h000A_0008);
        check("basic_t1", {27'h0, t1}, 32'd7);
        check("basic_v2_early", {31'h0, v2}, 32'h0);
        check("basic_b2", {31'h0, b2}, 32'h1);
        tick;
        check("basic_v1_off", {31'h0, v1}, 32'h0);
        check("basic_r1_hold", r1, 32'h000A_0008);
        check("basic_v2", {31'h0, v2}, 32'h1);
        check("basic_r2", r2, 32'h000A_0008);
        check("basic_t2", {27'h0, t2}, 32'd7);
        tick;
        check_idle("basic_end");
        check("basic_r2_hold", r2, 32'h000A_0008);

        // Wrap-around
        set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        check("wrap_p2", p2, 32'hFFFE_0001);
        m_vld = 1'b1;
        tick;
        m_vld = 1'b0;
        check("wrap_r1", r1, 32'h0000_0001);
        check("wrap_t1", {27'h0, t1}, 32'd31);
        tick;
        check("wrap_r2", r2, 32'h0000_0001);
        check("wrap_v2", {31'h0, v2}, 32'h1);
        tick;

        // Stall: a pending M_mul_valid during the stall must be ignored
        set_op(32'h1234_5678, 32'h0000_0010, 5'd3);
        m_vld = 1'b1;
        tick;
        set_op(32'h0000_0005, 32'h0000_0005, 5'd12);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("stall_v1", {31'h0, v1}, 32'h1);
            check("stall_r1", r1, 32'h2345_6780);
            check("stall_t1", {27'h0, t1}, 32'd3);
            check("stall_v2", {31'h0, v2}, 32'h0);
            check("stall_b2", {31'h0, b2}, 32'h1);
            check("stall_r2", r2, 32'h0000_0001);
        end
        m_vld = 1'b0;
        en = 1'b1;
        tick;
        check("stall_v1_off", {31'h0, v1}, 32'h0);
        check("stall_v2", {31'h0, v2}, 32'h1);
        check("stall_res2", r2, 32'h2345_6780);
        check("stall_tag2", {27'h0, t2}, 32'd3);
        tick;
        check_idle("stall_end");

        // Flush: three back-to-back ops, flush coincides with a fourth
        m_vld = 1'b1;
        set_op(32'h0000_0002, 32'h0000_0003, 5'd1);
        tick;
        check("fl_op1_r1", r1, 32'd6);
        set_op(32'h0000_0004, 32'h0000_0005, 5'd2);
        tick;
        check("fl_op1_r2", r2, 32'd6);
        check("fl_op2_r1", r1, 32'd20);
        set_op(32'h0000_0006, 32'h0000_0007, 5'd3);
        tick;
        check("fl_op2_r2", r2, 32'd20);
        set_op(32'h0000_0008, 32'h0000_0009, 5'd4);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        m_vld = 1'b0;
        check_idle("flush");
        for (int i = 0; i < 3; i++) begin
            tick;
            check_idle("flush_after");
        end

        // Flush wins over a stall
        set_op(32'h0000_0003, 32'h0000_0003, 5'd5);
        m_vld = 1'b1;
        tick;
        m_vld = 1'b0;
        en = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        en = 1'b1;
        check_idle("flush_stall");
        tick;
        check_idle("flush_stall_after");

        // Asynchronous reset with an op in flight
        set_op(32'h1234_5678, 32'h0000_0010, 5'd9);
        m_vld = 1'b1;
        tick;
        m_vld = 1'b0;
        check("rmid_r1_pre", r1, 32'h2345_6780);
        check("rmid_b2_pre", {31'h0, b2}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check_idle("rmid");
        check("rmid_r1", r1, 32'h0);
        check("rmid_r2", r2, 32'h0);
        check("rmid_t1", {27'h0, t1}, 32'h0);
        tick;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_idle("rmid_after");
        end

        // Streaming: 100 random back-to-back ops
        m_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s1 = $urandom;
            s2 = $urandom;
            tg = 5'($urandom_range(0, 31));
            prod = s1 * s2;
            set_op(s1, s2, tg);
            q1.push_back({tg, prod});
            q2.push_back({tg, prod});
            tick;
            mon;
        end
        m_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            mon;
        end
        check("stream_n1", n1, 32'd100);
        check("stream_n2", n2, 32'd100);
        check("stream_q1", q1.size(), 32'd0);
        check("stream_q2", q2.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/nios2_mul_result_combine.md
NIOS2_MUL_RESULT_COMBINE -- requirements
Module: nios2_mul_result_combine

Interface
REQ-001 SHALL have parameter LATENCY, default 2: cycles from M_mul_valid to A_mul_valid; legal values are 1 and 2.
REQ-002 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port M_mul_cell_p1, input, 32: partial product src1[15:0]*src2[15:0].
REQ-005 SHALL have port M_mul_cell_p2, input, 32: partial product src1[15:0]*src2[31:16].
REQ-006 SHALL have port M_mul_cell_p3, input, 32: partial product src1[31:16]*src2[15:0].
REQ-007 SHALL have port M_mul_valid, input, 1: the partial products are valid this cycle.
REQ-008 SHALL have port M_dst_regnum, input, 5: destination register tag accompanying the partials.
REQ-009 SHALL have port A_en, input, 1: pipeline advance enable; low means stall.
REQ-010 SHALL have port A_flush, input, 1: kill every in-flight operation.
REQ-011 SHALL have port A_mul_result, output, 32: low 32 bits of src1*src2.
REQ-012 SHALL have port A_mul_valid, output, 1: A_mul_result and A_dst_regnum are valid.
REQ-013 SHALL have port A_dst_regnum, output, 5: tag of the result.
REQ-014 SHALL have port A_mul_busy, output, 1: OR of all stage valid bits.

Function
REQ-015 SHALL compute A_mul_result = p1 + ({p2[15:0] + p3[15:0], 16'h0000}), all arithmetic modulo 2^32, with p2[31:16], p3[31:16] and every carry out of bit 15 of the mid sum discarded.
REQ-016 With LATENCY=2, stage 1 SHALL register p1, the 16-bit mid sum, the tag and a valid bit; stage 2 SHALL register the final add, the tag and a valid bit.
REQ-017 With LATENCY=1, the block SHALL have a single stage that registers the final result, the tag and a valid bit.
REQ-018 A stage SHALL load only when A_en=1; when A_en=0 every stage register SHALL hold its value.
REQ-019 An operation SHALL be captured only when M_mul_valid=1 and A_en=1; M_mul_valid with A_en=0 SHALL be ignored, because the upstream stage holds its data while stalled.
REQ-020 A_flush=1 SHALL clear every stage valid bit on the next edge, regardless of A_en; flush SHALL win over a simultaneous capture and over a simultaneous stall.
REQ-021 Data and tag registers SHALL NOT be cleared by flush; only valid bits are cleared.
REQ-022 Back-to-back M_mul_valid pulses with A_en=1 SHALL produce back-to-back A_mul_valid pulses, one result per cycle, in order.
REQ-023 When A_mul_valid=0, A_mul_result and A_dst_regnum SHALL hold their last values.
REQ-024 A_mul_busy SHALL be 1 whenever any stage valid bit is set.

Reset
REQ-025 Reset SHALL asynchronously clear every valid bit, data register and tag register to 0; A_mul_result=0, A_mul_valid=0, A_dst_regnum=0, A_mul_busy=0.
REQ-026 If reset asserts mid-operation, the in-flight operation SHALL be lost and SHALL NOT produce A_mul_valid after reset release.
REQ-027 The first capture SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-028 The shared CPU package SHALL hold the constants MUL_W=32, HALF_W=16 and REGNUM_W=5, and the LATENCY legality check.
REQ-029 One sub-module, nios2_mul_stage_reg, SHALL implement a valid-plus-payload stage register with enable and flush; it SHALL be instantiated once per stage.

Verification
REQ-030 Basic product: src1=0x00010002, src2=0x00030004 (p1=8, p2=6, p3=4), tag 7, A_en=1 -> A_mul_result=0x000A0008, A_dst_regnum=7, A_mul_valid high exactly LATENCY cycles later.
REQ-031 Wrap-around: src1=src2=0xFFFFFFFF (p1=p2=p3=0xFFFE0001) -> A_mul_result=0x00000001.
REQ-032 Stall: capture, then A_en=0 for 3 cycles -> all outputs frozen; the result appears LATENCY enabled cycles after capture, with no duplicate A_mul_valid.
REQ-033 Flush: three back-to-back ops, then A_flush together with a fourth M_mul_valid -> no A_mul_valid for any of them; A_mul_busy=0 the cycle after the flush.
REQ-034 Reset: assert reset while one op is in stage 1 -> all outputs 0 immediately; no A_mul_valid after release.
REQ-035 Streaming: 100 random back-to-back ops for both LATENCY values -> results equal (src1*src2) mod 2^32, in order, with matching tags.
